// File: rtl/periph_ctrl_multi_if.sv
// ---------------------------------------------------------------------------
// periph_ctrl_multi_if
// CPU data-bus bundle for the peripheral controller.
//   address     : register address (4 bits)
//   din         : write data (8 bits)
//   writeEnable : one-cycle write strobe
//   readEnable  : one-cycle read strobe
//   dout        : registered read data (8 bits)
// The master modport is the CPU side, the slave modport is the peripheral.
// ---------------------------------------------------------------------------
interface periph_ctrl_multi_if;
    logic [3:0] address;
    logic [7:0] din;
    logic       writeEnable;
    logic       readEnable;
    logic [7:0] dout;

    modport master (
        output address,
        output din,
        output writeEnable,
        output readEnable,
        input  dout
    );

    modport slave (
        input  address,
        input  din,
        input  writeEnable,
        input  readEnable,
        output dout
    );
endinterface

// File: rtl/periph_ctrl_multi.sv
// ---------------------------------------------------------------------------
// periph_ctrl_multi
// Memory-mapped peripheral controller: a bank of seven-segment digits with a
// decimal point, plus a debounced 4x4 keypad scanner feeding a key FIFO.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : CPU register bus (periph_ctrl_multi_if.slave)
//   hex    : segments, active-low, digit i at [7i+6:7i], bit0 = seg a
//   dot    : decimal point, active-low
//   rows   : keypad row drive, active-low one-hot
//   cols   : keypad column sense, active-low
// Register map: 0x0 KEY (read pops), 0x1 STATUS, 0x2 CTRL, 0x4+i DIGIT[i].
// ---------------------------------------------------------------------------
module periph_ctrl_multi #(
    parameter int N_DIGITS   = 11,
    parameter int FIFO_DEPTH = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    periph_ctrl_multi_if.slave      bus,
    output logic [7*N_DIGITS-1:0]   hex,
    output logic                    dot,
    output logic [3:0]              rows,
    input  logic [3:0]              cols
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DBC_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        KEY_IDLE    = 2'd0,
        KEY_CONFIRM = 2'd1,
        KEY_HELD    = 2'd2
    } key_state_t;

    // Common-anode hex decode, segment a in bit 0.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Number of pressed (low) columns, saturating at 2 meaning "more than one".
    function automatic logic [1:0] low_count(input logic [3:0] c);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            n = n + {2'd0, ~c[k]};
        end
        return (n > 3'd1) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest pressed column; only meaningful with exactly one low.
    function automatic logic [1:0] low_index(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (!c[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

    // Register file and bus state
    logic [2:0]       ctrl_r;
    logic [7:0]       digit_r [N_DIGITS];
    logic [7:0]       dout_r;
    logic [7:0]       digit_rd_s;

    // Scanner state
    logic [DIV_W-1:0] div_r;
    logic [1:0]       row_r;
    logic [3:0]       rows_r;
    logic [1:0]       hits_r;
    logic [3:0]       code_r;
    logic             sample_s;
    logic             scan_done_s;
    logic [1:0]       row_hits_s;
    logic [1:0]       total_hits_s;
    logic [3:0]       scan_code_s;
    logic             res_none_s;
    logic             res_one_s;

    // Key FSM
    key_state_t       key_state_r, key_state_nx;
    logic [3:0]       latch_r, latch_nx;
    logic [DBC_W-1:0] cnt_r, cnt_nx;
    logic             push_s;

    // FIFO
    logic [3:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [4:0]       count_r;
    logic             overflow_r;
    logic             empty_s, full_s, pop_s, push_ok_s, ovf_set_s, status_clr_s;

    assign sample_s     = (div_r == DIV_W'(SCAN_DIV - 1));
    assign scan_done_s  = sample_s && (row_r == 2'd3);
    assign row_hits_s   = low_count(cols);

    // Combine this row's presses with the ones already seen in the scan.
    always_comb begin
        total_hits_s = 2'd2;
        scan_code_s  = code_r;
        if (hits_r == 2'd0) begin
            total_hits_s = row_hits_s;
            scan_code_s  = {row_r, low_index(cols)};
        end else if (row_hits_s == 2'd0) begin
            total_hits_s = hits_r;
            scan_code_s  = code_r;
        end else begin
            total_hits_s = 2'd2;
            scan_code_s  = code_r;
        end
    end

    assign res_none_s = (total_hits_s == 2'd0);
    assign res_one_s  = (total_hits_s == 2'd1);

    // Row divider and active-low row rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r  <= '0;
            row_r  <= 2'd0;
            rows_r <= 4'b1110;
        end else if (sample_s) begin
            div_r  <= '0;
            row_r  <= row_r + 2'd1;
            rows_r <= {rows_r[2:0], rows_r[3]};
        end else begin
            div_r  <= div_r + DIV_W'(1);
        end
    end

    assign rows = rows_r;

    // Per-scan press accumulator, cleared at the end of every full scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_r <= 2'd0;
            code_r <= 4'd0;
        end else if (scan_done_s) begin
            hits_r <= 2'd0;
            code_r <= 4'd0;
        end else if (sample_s) begin
            hits_r <= total_hits_s;
            code_r <= scan_code_s;
        end
    end

    // Key FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_state_r <= KEY_IDLE;
            latch_r     <= 4'd0;
            cnt_r       <= '0;
        end else begin
            key_state_r <= key_state_nx;
            latch_r     <= latch_nx;
            cnt_r       <= cnt_nx;
        end
    end

    // Key FSM next state: evaluated once per completed scan.
    always_comb begin
        key_state_nx = key_state_r;
        latch_nx     = latch_r;
        cnt_nx       = cnt_r;
        push_s       = 1'b0;
        if (scan_done_s) begin
            case (key_state_r)
                KEY_IDLE: begin
                    if (res_one_s) begin
                        latch_nx = scan_code_s;
                        cnt_nx   = DBC_W'(1);
                        if (DEBOUNCE == 1) begin
                            push_s       = 1'b1;
                            key_state_nx = KEY_HELD;
                        end else begin
                            key_state_nx = KEY_CONFIRM;
                        end
                    end else begin
                        key_state_nx = KEY_IDLE;
                    end
                end
                KEY_CONFIRM: begin
                    if (res_one_s && (scan_code_s == latch_r)) begin
                        cnt_nx = cnt_r + DBC_W'(1);
                        if (cnt_r == DBC_W'(DEBOUNCE - 1)) begin
                            push_s       = 1'b1;
                            key_state_nx = KEY_HELD;
                        end else begin
                            key_state_nx = KEY_CONFIRM;
                        end
                    end else if (res_one_s) begin
                        latch_nx     = scan_code_s;
                        cnt_nx       = DBC_W'(1);
                        key_state_nx = KEY_CONFIRM;
                    end else begin
                        key_state_nx = KEY_IDLE;
                    end
                end
                KEY_HELD: begin
                    if (res_none_s) begin
                        key_state_nx = KEY_IDLE;
                    end else begin
                        key_state_nx = KEY_HELD;
                    end
                end
                default: begin
                    key_state_nx = KEY_IDLE;
                end
            endcase
        end else begin
            key_state_nx = key_state_r;
        end
    end

    assign empty_s      = (count_r == 5'd0);
    assign full_s       = (count_r == 5'(FIFO_DEPTH));
    assign pop_s        = bus.readEnable && (bus.address == 4'h0) && !empty_s;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is kept.
    assign push_ok_s    = push_s && (!full_s || pop_s);
    assign ovf_set_s    = push_s && full_s && !pop_s;
    assign status_clr_s = bus.writeEnable && (bus.address == 4'h1) && bus.din[2];

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= scan_code_s;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= 5'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
            // Setting wins over a same-cycle clear.
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (status_clr_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Control and digit register writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r <= 3'd0;
            for (int i = 0; i < N_DIGITS; i++) begin
                digit_r[i] <= 8'd0;
            end
        end else if (bus.writeEnable) begin
            if (bus.address == 4'h2) begin
                ctrl_r <= bus.din[2:0];
            end
            for (int i = 0; i < N_DIGITS; i++) begin
                if (bus.address == 4'(4 + i)) begin
                    digit_r[i] <= bus.din;
                end
            end
        end
    end

    // Digit readback mux; unmapped digit addresses read as zero.
    always_comb begin
        digit_rd_s = 8'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bus.address == 4'(4 + i)) begin
                digit_rd_s = digit_r[i];
            end
        end
    end

    // Registered read data; holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r <= 8'd0;
        end else if (bus.readEnable) begin
            case (bus.address)
                4'h0:    dout_r <= empty_s ? 8'd0 : {1'b1, 3'b000, mem_r[rd_ptr_r]};
                4'h1:    dout_r <= {count_r, overflow_r, full_s, empty_s};
                4'h2:    dout_r <= {5'd0, ctrl_r};
                default: dout_r <= digit_rd_s;
            endcase
        end
    end

    assign bus.dout = dout_r;

    // Segment drive: blank overrides, otherwise hex decode or raw (1 = lit).
    always_comb begin
        hex = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (ctrl_r[0]) begin
                hex[7*i +: 7] = 7'b1111111;
            end else if (ctrl_r[2]) begin
                hex[7*i +: 7] = seg_decode(digit_r[i][3:0]);
            end else begin
                hex[7*i +: 7] = ~digit_r[i][6:0];
            end
        end
    end

    assign dot = ctrl_r[0] ? 1'b1 : ~ctrl_r[1];

endmodule
